// File: rtl/fm_mod_matrix_sequencer_pkg.sv
// Shared types for the FM modulation-matrix sequencer: FSM states, select width, depth type, saturation.
// No latency or backpressure of its own; pure declarations and a combinational helper.
package fm_matrix_pkg;

  localparam int SEL_W       = 4;
  localparam int DEPTH_W_DEF = 8;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} seq_state_t;
  typedef logic [DEPTH_W_DEF-1:0] depth_t;

  // Clamp a wide signed value into the signed range of a dw-bit word.
  function automatic logic signed [63:0] sat_dwidth(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fm_mod_matrix_sequencer_if.sv
// Bundle between the sequencer, the operator output mux, the config port and the operator bank.
// No latency or backpressure; slave is the sequencer, master is its environment.
interface fm_mod_matrix_sequencer_if
  import fm_matrix_pkg::*;
#(
  parameter int DWIDTH  = 16,
  parameter int DEPTH_W = 8
) ();

  logic               sample_tick;
  logic               cfg_we;
  logic [SEL_W-1:0]   cfg_dst;
  logic [SEL_W-1:0]   cfg_src;
  logic [DEPTH_W-1:0] cfg_depth;
  logic [SEL_W-1:0]   mux_select;
  logic [DWIDTH-1:0]  mux_data;
  logic               mod_valid;
  logic [SEL_W-1:0]   mod_dst;
  logic [DWIDTH-1:0]  mod_data;
  logic               busy;
  logic               frame_done;
  logic               overrun;

  modport master (
    output sample_tick, cfg_we, cfg_dst, cfg_src, cfg_depth, mux_data,
    input  mux_select, mod_valid, mod_dst, mod_data, busy, frame_done, overrun
  );

  modport slave (
    input  sample_tick, cfg_we, cfg_dst, cfg_src, cfg_depth, mux_data,
    output mux_select, mod_valid, mod_dst, mod_data, busy, frame_done, overrun
  );

endinterface

// File: rtl/fm_mod_matrix_sequencer_depth_table.sv
// Depth table: writable shadow bank copied whole into the active bank on a frame-start strobe.
// Writes take one cycle, reads are combinational; no backpressure, out-of-range writes are dropped.
module fm_depth_table
  import fm_matrix_pkg::*;
#(
  parameter int OPS     = 8,
  parameter int DEPTH_W = 8,
  localparam int IDX_W  = $clog2(OPS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [SEL_W-1:0]   wr_dst,
  input  logic [SEL_W-1:0]   wr_src,
  input  logic [DEPTH_W-1:0] wr_depth,
  input  logic               copy,
  input  logic [IDX_W-1:0]   rd_dst,
  input  logic [IDX_W-1:0]   rd_src,
  output logic [DEPTH_W-1:0] rd_depth
);

  logic [DEPTH_W-1:0] shadow [OPS][OPS];
  logic [DEPTH_W-1:0] active [OPS][OPS];
  logic               wr_ok;

  assign wr_ok = wr_en && (32'(wr_dst) < OPS) && (32'(wr_src) < OPS);

  // A write landing on the copy edge reaches only the shadow; active takes the old contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < OPS; d++) begin
        for (int s = 0; s < OPS; s++) begin
          shadow[d][s] <= '0;
          active[d][s] <= '0;
        end
      end
    end else begin
      if (copy) active <= shadow;
      if (wr_ok) shadow[wr_dst[IDX_W-1:0]][wr_src[IDX_W-1:0]] <= wr_depth;
    end
  end

  assign rd_depth = active[rd_dst][rd_src];

endmodule

// File: rtl/fm_mod_matrix_sequencer.sv
// Per-sample FM matrix scheduler: scans every (dst,src), scales by depth, accumulates, saturates per dst.
// Result for dst d appears OPS+2+d*OPS cycles after the tick; no backpressure, ticks while busy set overrun.
module fm_mod_matrix_sequencer
  import fm_matrix_pkg::*;
#(
  parameter int OPS     = 8,
  parameter int DWIDTH  = 16,
  parameter int DEPTH_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  fm_mod_matrix_sequencer_if.slave bus
);

  localparam int IDX_W  = $clog2(OPS);
  localparam int PROD_W = DWIDTH + DEPTH_W + 1;
  localparam int ACC_W  = DWIDTH + DEPTH_W + $clog2(OPS) + 1;
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(OPS - 1);

  seq_state_t state, state_nxt;

  logic [SEL_W-1:0]   dst_cnt, src_cnt;
  logic               frame_start, scan_last;
  logic [DEPTH_W-1:0] depth_rd;

  logic                     p1_vld, p1_first, p1_last;
  logic [SEL_W-1:0]         p1_dst;
  logic signed [PROD_W-1:0] prod, p1_prod;
  logic signed [ACC_W-1:0]  acc, acc_nxt;

  logic               mod_valid_q, frame_done_q, overrun_q;
  logic [SEL_W-1:0]   mod_dst_q;
  logic [DWIDTH-1:0]  mod_data_q;

  assign frame_start = (state == IDLE) && bus.sample_tick;
  assign scan_last   = (state == SCAN) && (dst_cnt == LAST_IDX) && (src_cnt == LAST_IDX);

  fm_depth_table #(.OPS(OPS), .DEPTH_W(DEPTH_W)) u_depth_table (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (bus.cfg_we),
    .wr_dst   (bus.cfg_dst),
    .wr_src   (bus.cfg_src),
    .wr_depth (bus.cfg_depth),
    .copy     (frame_start),
    .rd_dst   (dst_cnt[IDX_W-1:0]),
    .rd_src   (src_cnt[IDX_W-1:0]),
    .rd_depth (depth_rd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // DRAIN ends on the cycle the final result is presented, so the pipeline is empty by IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.sample_tick) state_nxt = SCAN;
      SCAN:    if (scan_last)       state_nxt = DRAIN;
      DRAIN:   if (frame_done_q)    state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dst_cnt <= '0;
      src_cnt <= '0;
    end else if (frame_start || scan_last) begin
      dst_cnt <= '0;
      src_cnt <= '0;
    end else if (state == SCAN) begin
      if (src_cnt == LAST_IDX) begin
        src_cnt <= '0;
        dst_cnt <= dst_cnt + 1'b1;
      end else begin
        src_cnt <= src_cnt + 1'b1;
      end
    end
  end

  assign bus.mux_select = (state == SCAN) ? src_cnt : '0;

  assign prod = PROD_W'($signed(bus.mux_data)) * PROD_W'($signed({1'b0, depth_rd}));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p1_vld   <= 1'b0;
      p1_first <= 1'b0;
      p1_last  <= 1'b0;
      p1_dst   <= '0;
      p1_prod  <= '0;
    end else begin
      p1_vld   <= (state == SCAN);
      p1_first <= (state == SCAN) && (src_cnt == '0);
      p1_last  <= (state == SCAN) && (src_cnt == LAST_IDX);
      p1_dst   <= dst_cnt;
      p1_prod  <= prod;
    end
  end

  assign acc_nxt = p1_first ? ACC_W'(p1_prod) : acc + ACC_W'(p1_prod);

  // Accumulator is wide enough for OPS full-scale products, so only the final word saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc          <= '0;
      mod_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      mod_dst_q    <= '0;
      mod_data_q   <= '0;
    end else begin
      if (p1_vld) acc <= acc_nxt;
      mod_valid_q  <= p1_vld && p1_last;
      frame_done_q <= p1_vld && p1_last && (p1_dst == LAST_IDX);
      if (p1_vld && p1_last) begin
        mod_dst_q  <= p1_dst;
        mod_data_q <= DWIDTH'(sat_dwidth(64'(acc_nxt) >>> DEPTH_W, DWIDTH));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                overrun_q <= 1'b0;
    else if (bus.sample_tick && state != IDLE) overrun_q <= 1'b1;
  end

  assign bus.mod_valid  = mod_valid_q;
  assign bus.mod_dst    = mod_dst_q;
  assign bus.mod_data   = mod_data_q;
  assign bus.frame_done = frame_done_q;
  assign bus.busy       = (state != IDLE);
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_fm_mod_matrix_sequencer.sv
// Bench for fm_mod_matrix_sequencer: vector table, hand-written corner sequences, random frames vs a sum model.
// The operator mux is modelled as a combinational lookup of src_val by mux_select.
module tb_fm_mod_matrix_sequencer;
  import fm_matrix_pkg::*;

  localparam int OPS       = 8;
  localparam int DWIDTH    = 16;
  localparam int DEPTH_W   = 8;
  localparam int FRAME_LEN = OPS * OPS + 2;

  typedef struct {
    int     dst;
    int     src;
    depth_t depth;
    int     sval;
    int     exp;
  } tv_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fm_mod_matrix_sequencer_if #(.DWIDTH(DWIDTH), .DEPTH_W(DEPTH_W)) bus ();

  fm_mod_matrix_sequencer #(.OPS(OPS), .DWIDTH(DWIDTH), .DEPTH_W(DEPTH_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int src_val [16];
  int dep_m   [OPS][OPS];
  int got_data[OPS];
  int got_cnt;
  int n_chk  = 0;
  int n_fail = 0;
  tv_t tv[7];

  assign bus.mux_data = DWIDTH'(src_val[bus.mux_select]);

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected word: exact sum of products, floor-divided by 2^DEPTH_W, clamped to DWIDTH.
  function automatic longint model_dst(input int d);
    longint sum;
    longint q;
    sum = 0;
    for (int s = 0; s < OPS; s++) sum += longint'(src_val[s]) * longint'(dep_m[d][s]);
    if (sum >= 0) q = sum / 256;
    else          q = -((-sum + 255) / 256);
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return q;
  endfunction

  task automatic clear_model();
    for (int d = 0; d < OPS; d++)
      for (int s = 0; s < OPS; s++) dep_m[d][s] = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_model();
  endtask

  task automatic randomize_srcs();
    for (int i = 0; i < 16; i++) src_val[i] = int'($urandom_range(0, 65535)) - 32768;
  endtask

  task automatic cfg_write(input int d, input int s, input int v);
    bus.cfg_we    = 1'b1;
    bus.cfg_dst   = SEL_W'(d);
    bus.cfg_src   = SEL_W'(s);
    bus.cfg_depth = depth_t'(v);
    @(posedge clk);
    #1;
    bus.cfg_we = 1'b0;
    if (d < OPS && s < OPS) dep_m[d][s] = v;
  endtask

  // Tick in cycle 0, then check every cycle up to the last strobe; returns at the start of cycle 67.
  task automatic run_frame(input int tick2_at, input int wr_at, input int wr_d, input int wr_s, input int wr_v);
    logic [10:0] act, exp;
    bit          e_vld;
    int          e_sel;
    got_cnt = 0;
    for (int d = 0; d < OPS; d++) got_data[d] = 99999;
    for (int c = 0; c <= FRAME_LEN; c++) begin
      bus.sample_tick = (c == 0) || (c == tick2_at);
      bus.cfg_we      = (c == wr_at);
      bus.cfg_dst     = SEL_W'(wr_d);
      bus.cfg_src     = SEL_W'(wr_s);
      bus.cfg_depth   = depth_t'(wr_v);
      @(negedge clk);
      if (c > 0) begin
        e_vld = (c >= OPS + 2) && ((c - OPS - 2) % OPS == 0);
        e_sel = (c <= OPS * OPS) ? (c - 1) % OPS : 0;
        exp = {e_vld, 1'b1, (c == FRAME_LEN), 4'(e_sel), e_vld ? 4'((c - OPS - 2) / OPS) : 4'd0};
        act = {bus.mod_valid, bus.busy, bus.frame_done, bus.mux_select,
               bus.mod_valid ? bus.mod_dst : 4'd0};
        check($sformatf("timing T+%0d {vld,busy,done,sel,dst}", c), act, exp);
        if (bus.mod_valid && bus.mod_dst < OPS) begin
          got_data[bus.mod_dst] = int'($signed(bus.mod_data));
          got_cnt++;
        end
      end
      @(posedge clk);
      #1;
    end
    bus.sample_tick = 1'b0;
    bus.cfg_we      = 1'b0;
  endtask

  task automatic check_frame(input string name);
    check({name, " strobe count"}, got_cnt, OPS);
    for (int d = 0; d < OPS; d++) check($sformatf("%s dst%0d", name, d), got_data[d], model_dst(d));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset           = 1'b1;
    bus.sample_tick = 1'b0;
    bus.cfg_we      = 1'b0;
    bus.cfg_dst     = '0;
    bus.cfg_src     = '0;
    bus.cfg_depth   = '0;
    for (int i = 0; i < 16; i++) src_val[i] = 0;
    clear_model();

    tv[0] = '{2, 5, 8'd128, 1000, 500};
    tv[1] = '{2, 5, 8'd128, -1001, -501};
    tv[2] = '{0, 0, 8'd255, 32767, 32639};
    tv[3] = '{3, 1, 8'd255, -32768, -32640};
    tv[4] = '{7, 7, 8'd1, -1, -1};
    tv[5] = '{4, 6, 8'd0, 12345, 0};
    tv[6] = '{6, 3, 8'd200, -300, -235};

    #1;
    check("reset outputs", {bus.mod_valid, bus.busy, bus.frame_done, bus.overrun,
                            bus.mux_select, bus.mod_dst, bus.mod_data}, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Zero depths: every destination reads 0 regardless of source values.
    for (int i = 0; i < OPS; i++) src_val[i] = 1000 + 37 * i;
    run_frame(-1, -1, 0, 0, 0);
    check_frame("t1");
    check("t1 overrun", bus.overrun, 0);

    // Single-pair vectors; unrelated sources carry random data.
    for (int k = 0; k < 7; k++) begin
      do_reset();
      randomize_srcs();
      src_val[tv[k].src] = tv[k].sval;
      cfg_write(tv[k].dst, tv[k].src, int'(tv[k].depth));
      run_frame(-1, -1, 0, 0, 0);
      check($sformatf("vec%0d dst%0d", k, tv[k].dst), got_data[tv[k].dst], tv[k].exp);
      check_frame($sformatf("vec%0d", k));
    end

    // Saturation in both directions.
    do_reset();
    for (int s = 0; s < OPS; s++) cfg_write(0, s, 255);
    for (int i = 0; i < OPS; i++) src_val[i] = 32767;
    run_frame(-1, -1, 0, 0, 0);
    check("sat pos dst0", got_data[0], 32767);
    check_frame("sat pos");
    for (int i = 0; i < OPS; i++) src_val[i] = -32768;
    run_frame(-1, -1, 0, 0, 0);
    check("sat neg dst0", got_data[0], -32768);
    check_frame("sat neg");

    // Tick while busy is ignored and sets sticky overrun.
    do_reset();
    randomize_srcs();
    src_val[5] = 1000;
    cfg_write(2, 5, 128);
    run_frame(20, -1, 0, 0, 0);
    check("ovr dst2", got_data[2], 500);
    check_frame("ovr");
    check("ovr overrun set", bus.overrun, 1);
    run_frame(-1, -1, 0, 0, 0);
    check_frame("ovr next");
    check("ovr overrun sticky", bus.overrun, 1);

    // Shadow-bank timing of config writes; out-of-range writes are dropped.
    do_reset();
    randomize_srcs();
    src_val[5] = 1000;
    cfg_write(2, 5, 128);
    run_frame(-1, 30, 2, 5, 64);
    check("cfg midframe dst2", got_data[2], 500);
    check_frame("cfg midframe");
    dep_m[2][5] = 64;
    run_frame(-1, -1, 0, 0, 0);
    check("cfg next dst2", got_data[2], 250);
    run_frame(-1, 0, 2, 5, 128);
    check("cfg ontick dst2", got_data[2], 250);
    check_frame("cfg ontick");
    dep_m[2][5] = 128;
    cfg_write(8, 5, 255);
    cfg_write(2, 9, 255);
    cfg_write(15, 12, 255);
    run_frame(-1, -1, 0, 0, 0);
    check("cfg after dst2", got_data[2], 500);
    check_frame("cfg oob");

    // Reset mid-frame: outputs drop immediately, frame abandoned, tables cleared.
    do_reset();
    randomize_srcs();
    src_val[5] = 1000;
    cfg_write(2, 5, 128);
    bus.sample_tick = 1'b1;
    @(posedge clk);
    #1;
    bus.sample_tick = 1'b0;
    repeat (29) @(posedge clk);
    #3;
    check("rst pre select", bus.mux_select, 5);
    reset = 1'b1;
    #1;
    check("rst immediate {busy,vld,sel,done}",
          {bus.busy, bus.mod_valid, bus.mux_select, bus.frame_done}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_model();
    n = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (bus.mod_valid || bus.busy) n++;
    end
    check("rst no activity after release", n, 0);
    @(posedge clk);
    #1;
    randomize_srcs();
    run_frame(-1, -1, 0, 0, 0);
    check_frame("rst reload");

    // Random depth tables and sources against the sum model.
    do_reset();
    for (int it = 0; it < 3; it++) begin
      for (int d = 0; d < OPS; d++)
        for (int s = 0; s < OPS; s++) cfg_write(d, s, int'($urandom_range(0, 255)));
      randomize_srcs();
      run_frame(-1, -1, 0, 0, 0);
      check_frame($sformatf("rand%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
